// File: rtl/craft_dec_serial_core_pkg.sv
// Shared encodings, FSM states and index helpers for the nibble-serial
// CRAFT decryption-direction state engine.
package craft_dec_serial_core_pkg;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_SUB  = 2'd1;
  localparam logic [1:0] PH_PN   = 2'd2;
  localparam logic [1:0] PH_MIX  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_PN   = 2'd2;
  localparam logic [1:0] OP_MIX  = 2'd3;

  localparam int SUB_LEN = 16;
  localparam int MIX_LEN = 4;

  // Nibble i of this constant is the source index for destination nibble i.
  localparam logic [63:0] PN_TABLE = 64'hFCDEA98B65471230;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SUB  = 3'd1,
    ST_PN   = 3'd2,
    ST_MIX  = 3'd3,
    ST_DONE = 3'd4
  } fsm_e;

  // Nibble 0 is the most significant nibble of the 64-bit state.
  function automatic int nib_lsb(input int idx);
    return (32'sd15 - idx) * 32'sd4;
  endfunction

endpackage

// File: rtl/craft_dec_serial_core_if.sv
// Start/result handshake and external-transform nibble bus of the
// CRAFT decryption state engine.
interface craft_dec_serial_core_if #(
  parameter int RW = 5
);
  logic          start;
  logic [63:0]   ciphertext;
  logic          ready;
  logic [3:0]    in;
  logic [3:0]    out;
  logic [1:0]    phase;
  logic [RW-1:0] round;
  logic          done;
  logic          ack;
  logic [63:0]   state_registers;

  modport master (
    output start, ciphertext, in, ack,
    input  ready, out, phase, round, done, state_registers
  );

  modport slave (
    input  start, ciphertext, in, ack,
    output ready, out, phase, round, done, state_registers
  );
endinterface

// File: rtl/craft_inv_state_register.sv
// 64-bit nibble state register: load, serial S-box rotation, nibble
// permutation and reverse column feed, selected by op_i.
module craft_inv_state_register
  import craft_dec_serial_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_i,
  input  logic [1:0]  op_i,
  input  logic [3:0]  in_i,
  input  logic [63:0] ciphertext_i,
  output logic [3:0]  out_o,
  output logic [63:0] state_o
);

  logic [63:0] state_q;
  logic [63:0] state_d;

  // Next-state selection for the requested operation.
  always_comb begin
    state_d = state_q;
    case (op_i)
      OP_LOAD: state_d = ciphertext_i;
      OP_SUB:  state_d = {state_q[59:0], in_i};
      OP_PN: begin
        for (int i = 0; i < 16; i++) begin
          state_d[nib_lsb(i) +: 4] =
            state_q[nib_lsb(int'(PN_TABLE[nib_lsb(i) +: 4])) +: 4];
        end
      end
      OP_MIX: begin
        // Column 3 shifts one nibble toward n15; the transformed nibble enters at n3.
        state_d[nib_lsb(15) +: 4] = state_q[nib_lsb(11) +: 4];
        state_d[nib_lsb(11) +: 4] = state_q[nib_lsb(7) +: 4];
        state_d[nib_lsb(7) +: 4]  = state_q[nib_lsb(3) +: 4];
        state_d[nib_lsb(3) +: 4]  = in_i;
      end
      default: state_d = state_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 64'd0;
    end else if (ce_i) begin
      state_q <= state_d;
    end
  end

  // MIX feeds n15 outward; every other op presents n0.
  always_comb begin
    if (op_i == OP_MIX) begin
      out_o = state_q[nib_lsb(15) +: 4];
    end else begin
      out_o = state_q[nib_lsb(0) +: 4];
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/craft_dec_serial_core.sv
// CRAFT decryption-direction sequencer: start/done handshakes, round and
// step counters around the nibble-serial state register.
module craft_dec_serial_core
  import craft_dec_serial_core_pkg::*;
#(
  parameter int ROUNDS = 32,
  parameter int RW     = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  craft_dec_serial_core_if.slave  bus
);

  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
  localparam logic [3:0]    SUB_LAST   = 4'(SUB_LEN - 1);
  localparam logic [3:0]    MIX_LAST   = 4'(MIX_LEN - 1);

  fsm_e          state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [RW-1:0] round_q, round_d;
  logic          reg_en_s;
  logic [1:0]    reg_op_s;
  logic [1:0]    phase_s;

  // FSM and counter registers; ce low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= 4'd0;
      round_q <= '0;
    end else if (ce) begin
      state_q <= state_d;
      step_q  <= step_d;
      round_q <= round_d;
    end
  end

  // Next-state, counter updates and state-register op select.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    round_d  = round_q;
    reg_en_s = 1'b0;
    reg_op_s = OP_LOAD;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SUB;
          step_d   = 4'd0;
          round_d  = '0;
          reg_en_s = 1'b1;
          reg_op_s = OP_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SUB: begin
        reg_en_s = 1'b1;
        reg_op_s = OP_SUB;
        if (step_q == SUB_LAST) begin
          state_d = ST_PN;
          step_d  = 4'd0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      ST_PN: begin
        reg_en_s = 1'b1;
        reg_op_s = OP_PN;
        state_d  = ST_MIX;
        step_d   = 4'd0;
      end
      ST_MIX: begin
        reg_en_s = 1'b1;
        reg_op_s = OP_MIX;
        if (step_q == MIX_LAST) begin
          step_d = 4'd0;
          if (round_q == LAST_ROUND) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SUB;
            round_d = round_q + RW'(1);
          end
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (bus.ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 4'd0;
        round_d = '0;
      end
    endcase
  end

  // Phase code presented to the external transform logic.
  always_comb begin
    case (state_q)
      ST_SUB:  phase_s = PH_SUB;
      ST_PN:   phase_s = PH_PN;
      ST_MIX:  phase_s = PH_MIX;
      default: phase_s = PH_IDLE;
    endcase
  end

  craft_inv_state_register u_state (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce_i         (ce && reg_en_s),
    .op_i         (reg_op_s),
    .in_i         (bus.in),
    .ciphertext_i (bus.ciphertext),
    .out_o        (bus.out),
    .state_o      (bus.state_registers)
  );

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.phase = phase_s;
  assign bus.round = round_q;

endmodule

// File: tb/tb_craft_dec_serial_core.sv
// Bench for craft_dec_serial_core: directed single-round instance plus a
// randomized 32-round instance compared every cycle against a block-level model.
module tb_craft_dec_serial_core;

  localparam int B_ROUNDS = 32;
  localparam int B_LAT    = 21 * B_ROUNDS;

  logic clk;
  logic rst_n = 1'b0;
  logic ce_a  = 1'b1;
  logic ce_b  = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  craft_dec_serial_core_if #(.RW(1)) bus_a ();
  craft_dec_serial_core_if #(.RW(5)) bus_b ();

  craft_dec_serial_core #(.ROUNDS(1), .RW(1)) u_a (
    .clk(clk), .rst_n(rst_n), .ce(ce_a), .bus(bus_a)
  );
  craft_dec_serial_core #(.ROUNDS(B_ROUNDS), .RW(5)) u_b (
    .clk(clk), .rst_n(rst_n), .ce(ce_b), .bus(bus_b)
  );

  logic [15:0][3:0] sb_b;
  logic [15:0][3:0] mx_b;
  int pn_idx [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
  logic [3:0] mix_exp [4] = '{4'h0, 4'h7, 4'hB, 4'hE};

  // External logic: A is identity S-box and zero MixColumn feed, B uses random tables.
  assign bus_a.in = (bus_a.phase == 2'd3) ? 4'h0 : bus_a.out;
  assign bus_b.in = (bus_b.phase == 2'd3) ? mx_b[bus_b.out] : sb_b[bus_b.out];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [63:0] s, input int i);
    return s[(15 - i) * 4 +: 4];
  endfunction

  function automatic logic [63:0] f_sub(input logic [63:0] s, input logic [15:0][3:0] sb);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[(15 - i) * 4 +: 4] = sb[nib(s, i)];
    return r;
  endfunction

  function automatic logic [63:0] f_pn(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[(15 - i) * 4 +: 4] = nib(s, pn_idx[i]);
    return r;
  endfunction

  function automatic logic [63:0] f_mix(input logic [63:0] s, input logic [15:0][3:0] mx);
    logic [63:0] r;
    r = s;
    for (int c = 3; c < 16; c += 4) r[(15 - c) * 4 +: 4] = mx[nib(s, c)];
    return r;
  endfunction

  // State after w serial S-box edges: w nibbles rotated out and transformed.
  function automatic logic [63:0] f_sub_part(input logic [63:0] s, input int w,
                                             input logic [15:0][3:0] sb);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) begin
      if (i < 16 - w) r[(15 - i) * 4 +: 4] = nib(s, i + w);
      else            r[(15 - i) * 4 +: 4] = sb[nib(s, i - 16 + w)];
    end
    return r;
  endfunction

  // Block-level model of instance B: idle / busy(ce-edge count) / done.
  int          m_mode = 0;
  int          m_cnt  = 0;
  logic [63:0] rs_tab [0:B_ROUNDS];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_cnt  = 0;
    end else if (ce_b) begin
      case (m_mode)
        0: if (bus_b.start) begin
          m_mode = 1;
          m_cnt  = 0;
          rs_tab[0] = bus_b.ciphertext;
          for (int r = 1; r <= B_ROUNDS; r++)
            rs_tab[r] = f_mix(f_pn(f_sub(rs_tab[r-1], sb_b)), mx_b);
        end
        1: begin
          m_cnt++;
          if (m_cnt == B_LAT) m_mode = 2;
        end
        default: if (bus_b.ack) m_mode = 0;
      endcase
    end
  end

  // Per-cycle comparison of instance B against the model.
  always @(negedge clk) begin : cmp_b
    int r, w, s;
    logic [63:0] pn;
    if (rst_n) begin
      case (m_mode)
        0: begin
          chk("b_idle_ready", 64'(bus_b.ready), 64'd1);
          chk("b_idle_done", 64'(bus_b.done), 64'd0);
          chk("b_idle_phase", 64'(bus_b.phase), 64'd0);
        end
        1: begin
          r = m_cnt / 21;
          w = m_cnt % 21;
          chk("b_busy_ready", 64'(bus_b.ready), 64'd0);
          chk("b_busy_done", 64'(bus_b.done), 64'd0);
          chk("b_round", 64'(bus_b.round), 64'(r));
          chk("b_phase", 64'(bus_b.phase), (w < 16) ? 64'd1 : (w == 16) ? 64'd2 : 64'd3);
          if (w < 16) begin
            chk("b_sub_out", 64'(bus_b.out), 64'(nib(rs_tab[r], w)));
            chk("b_sub_state", bus_b.state_registers, f_sub_part(rs_tab[r], w, sb_b));
          end else if (w == 16) begin
            chk("b_pn_in_state", bus_b.state_registers, f_sub(rs_tab[r], sb_b));
          end else begin
            s  = w - 17;
            pn = f_pn(f_sub(rs_tab[r], sb_b));
            chk("b_mix_out", 64'(bus_b.out), 64'(nib(pn, 15 - 4 * s)));
            if (s == 0) chk("b_mix_state", bus_b.state_registers, pn);
          end
        end
        default: begin
          chk("b_done", 64'(bus_b.done), 64'd1);
          chk("b_done_ready", 64'(bus_b.ready), 64'd0);
          chk("b_done_phase", 64'(bus_b.phase), 64'd0);
          chk("b_done_round", 64'(bus_b.round), 64'(B_ROUNDS - 1));
          chk("b_result", bus_b.state_registers, rs_tab[B_ROUNDS]);
        end
      endcase
    end
  end

  task automatic b_prepare();
    for (int v = 0; v < 16; v++) begin
      sb_b[v] = 4'($urandom);
      mx_b[v] = 4'($urandom);
    end
    bus_b.ciphertext = {$urandom, $urandom};
  endtask

  task automatic run_b_block(input bit rnd, input bit both);
    int guard;
    b_prepare();
    ce_b = 1'b1; bus_b.ack = 1'b0; bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    guard = 0;
    while (!bus_b.done && guard < 4000) begin
      if (rnd) begin
        ce_b        = ($urandom_range(0, 9) != 0);
        bus_b.start = ($urandom_range(0, 7) == 0);
        bus_b.ack   = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      guard++;
    end
    chk("b_done_wait", 64'(guard < 4000), 64'd1);
    ce_b = 1'b1; bus_b.ack = 1'b0; bus_b.start = 1'b0;
    repeat ($urandom_range(1, 6)) begin
      bus_b.start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus_b.ack = 1'b1; bus_b.start = both;
    guard = 0;
    while (m_mode != 0 && guard < 50) begin
      if (rnd) ce_b = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
    end
    chk("b_ack_wait", 64'(guard < 50), 64'd1);
    bus_b.ack = 1'b0; bus_b.start = 1'b0; ce_b = 1'b1;
    @(negedge clk);
  endtask

  initial begin : stim
    int lat;
    int guard;
    bus_a.start = 1'b0; bus_a.ack = 1'b0; bus_a.ciphertext = 64'd0;
    bus_b.start = 1'b0; bus_b.ack = 1'b0; bus_b.ciphertext = 64'd0;
    sb_b = '0; mx_b = '0;

    #3;
    chk("a_rst_state", bus_a.state_registers, 64'd0);
    chk("a_rst_ready", 64'(bus_a.ready), 64'd1);
    chk("a_rst_done", 64'(bus_a.done), 64'd0);
    chk("a_rst_round", 64'(bus_a.round), 64'd0);
    chk("a_rst_phase", 64'(bus_a.phase), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("model_sub_id", f_sub(64'h0123456789ABCDEF, 64'hFEDCBA9876543210), 64'h0123456789ABCDEF);
    chk("model_sub_inc", f_sub(64'h0123456789ABCDEF, 64'h0FEDCBA987654321), 64'h123456789ABCDEF0);
    chk("model_pn", f_pn(64'h0123456789ABCDEF), 64'hFCDEA98B65471230);
    chk("model_mix", f_mix(64'hFCDEA98B65471230, 64'd0), 64'hFCD0A98065401230);

    // Single-round directed run.
    @(negedge clk);
    bus_a.ciphertext = 64'h0123456789ABCDEF; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    chk("a_sub_phase", 64'(bus_a.phase), 64'd1);
    chk("a_busy_ready", 64'(bus_a.ready), 64'd0);
    repeat (16) @(negedge clk);
    chk("a_sub_identity", bus_a.state_registers, 64'h0123456789ABCDEF);
    chk("a_pn_phase", 64'(bus_a.phase), 64'd2);
    @(negedge clk);
    chk("a_pn_state", bus_a.state_registers, 64'hFCDEA98B65471230);
    for (int j = 0; j < 4; j++) begin
      chk("a_mix_phase", 64'(bus_a.phase), 64'd3);
      chk("a_mix_out", 64'(bus_a.out), 64'(mix_exp[j]));
      chk("a_mix_nodone", 64'(bus_a.done), 64'd0);
      @(negedge clk);
    end
    chk("a_done_21", 64'(bus_a.done), 64'd1);
    chk("a_result", bus_a.state_registers, 64'hFCD0A98065401230);
    chk("a_done_ready", 64'(bus_a.ready), 64'd0);
    chk("a_done_phase", 64'(bus_a.phase), 64'd0);
    repeat (10) begin
      @(negedge clk);
      chk("a_hold_done", 64'(bus_a.done), 64'd1);
      chk("a_hold_state", bus_a.state_registers, 64'hFCD0A98065401230);
    end
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    chk("a_start_in_done", 64'(bus_a.done), 64'd1);
    chk("a_start_in_done_rdy", 64'(bus_a.ready), 64'd0);
    bus_a.ack = 1'b1;
    @(negedge clk);
    bus_a.ack = 1'b0;
    chk("a_ack_done", 64'(bus_a.done), 64'd0);
    chk("a_ack_ready", 64'(bus_a.ready), 64'd1);
    @(negedge clk);
    chk("a_no_queue_phase", 64'(bus_a.phase), 64'd0);
    chk("a_no_queue_ready", 64'(bus_a.ready), 64'd1);

    // Clock-enable gating mid-SUB.
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    lat = 0;
    repeat (7) begin @(negedge clk); lat++; end
    ce_a = 1'b0;
    repeat (5) begin
      @(negedge clk); lat++;
      chk("a_ce_state", bus_a.state_registers, 64'h789ABCDEF0123456);
      chk("a_ce_out", 64'(bus_a.out), 64'h7);
      chk("a_ce_phase", 64'(bus_a.phase), 64'd1);
    end
    ce_a = 1'b1;
    while (!bus_a.done && lat < 200) begin @(negedge clk); lat++; end
    chk("a_ce_latency", 64'(lat), 64'd26);
    chk("a_ce_result", bus_a.state_registers, 64'hFCD0A98065401230);
    bus_a.ack = 1'b1;
    @(negedge clk);
    bus_a.ack = 1'b0;
    chk("a_ce_ack_ready", 64'(bus_a.ready), 64'd1);

    // Randomized 32-round blocks.
    run_b_block(1'b1, 1'b0);
    run_b_block(1'b1, 1'b1);
    run_b_block(1'b0, 1'b1);

    // Asynchronous reset at round 3, SUB step 7.
    b_prepare();
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    guard = 0;
    while (!(m_mode == 1 && m_cnt == 70) && guard < 200) begin @(negedge clk); guard++; end
    chk("b_rst_reach", 64'(guard < 200), 64'd1);
    chk("b_rst_pre_round", 64'(bus_b.round), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("b_rst_state", bus_b.state_registers, 64'd0);
    chk("b_rst_ready", 64'(bus_b.ready), 64'd1);
    chk("b_rst_done", 64'(bus_b.done), 64'd0);
    chk("b_rst_round", 64'(bus_b.round), 64'd0);
    chk("b_rst_phase", 64'(bus_b.phase), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    b_prepare();
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    lat = 0;
    while (!bus_b.done && lat < 2000) begin @(negedge clk); lat++; end
    chk("b_latency", 64'(lat), 64'd672);
    bus_b.ack = 1'b1;
    @(negedge clk);
    bus_b.ack = 1'b0;
    chk("b_final_ready", 64'(bus_b.ready), 64'd1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
